// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
//   Two-master (m0 = fetch, m1 = load/store) round-robin arbiter in front of a
//   single data-bus control port. One transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Illegal size or misalignment is
//   caught in ISSUE and short-circuits to RESP with err. A shared 8-bit
//   timeout counter runs across ISSUE and WAIT.
//
// Parameters
//   RD_LAT   minimum cycles from bus strobe to read-data sample (1..15)
//   TIMEOUT  max ISSUE+WAIT cycles before error termination   (1..255)
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   mN_req/we/size/addr/wdata     master N request (held until mN_ack)
//   mN_ack/err/rdata              master N completion pulse, error, read data
//   bus_rd, bus_wd                one-cycle read / write strobes
//   bus_size/addr/wdata           access attributes, stable for the transaction
//   bus_rdata/ready/busy          bus response and status
// -----------------------------------------------------------------------------

// Per-master response registers: ack/err pulse and held read data.
module dbus_arb_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire_i,   // RESP cycle for this master
  input  logic        err_i,
  input  logic        upd_i,    // successful read: load rdata
  input  logic [31:0] rdata_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);
  logic        ack_q, err_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= fire_i;
      err_q <= fire_i & err_i;
      if (fire_i && upd_i) rdata_q <= rdata_i;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
endmodule

module dbus_arbiter #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (fetch)
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  // master 1 (load/store)
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  // data bus control
  output logic        bus_rd,
  output logic        bus_wd,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  input  logic        bus_busy
);
  localparam int         NUM_M  = 2;
  localparam logic [3:0] RLAT_C = 4'(RD_LAT);
  localparam logic [8:0] TMO_C  = 9'(TIMEOUT);

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // packed per-master views
  req_t [NUM_M-1:0]              mreq;
  logic [NUM_M-1:0]              req_v, ack_v, err_v, fire_v;
  logic [NUM_M-1:0][31:0]        rdata_v;

  assign mreq[0] = {m0_we, m0_size, m0_addr, m0_wdata};
  assign mreq[1] = {m1_we, m1_size, m1_addr, m1_wdata};
  assign req_v   = {m1_req, m0_req};

  state_t      state_q, state_d;
  req_t        cur_q;                 // latched winner request, drives bus attrs
  logic        gnt_q;                 // last-granted master == current owner
  logic [7:0]  tcnt_q, tcnt_d;        // ISSUE+WAIT timeout counter
  logic [3:0]  wcnt_q, wcnt_d;        // cycles since strobe
  logic        err_q, err_d;          // transaction error
  logic        rd_q, rd_d, wd_q, wd_d;
  logic [31:0] rdstg_q;               // read data staged until RESP
  logic        grant, pick, cap, done;
  logic [NUM_M-1:0] elig;
  logic        illegal, bus_ok, tmo;
  logic [8:0]  tcnt_inc;
  logic [3:0]  wcnt_inc;

  // A master whose ack is showing is still holding req this cycle; masking it
  // stops a spurious re-grant of the transaction that just finished.
  assign elig = req_v & ~ack_v;
  assign pick = (elig == 2'b11) ? ~gnt_q : elig[1];

  assign illegal = (cur_q.size == 2'b11) ||
                   (cur_q.size == 2'b01 && cur_q.addr[0]) ||
                   (cur_q.size == 2'b10 && cur_q.addr[1:0] != 2'b00);
  assign bus_ok   = bus_ready & ~bus_busy;
  assign tcnt_inc = {1'b0, tcnt_q} + 9'd1;
  assign tmo      = tcnt_inc >= TMO_C;
  assign wcnt_inc = (wcnt_q == 4'hF) ? 4'hF : wcnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    rd_d    = 1'b0;
    wd_d    = 1'b0;
    grant   = 1'b0;
    cap     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          grant   = 1'b1;
          tcnt_d  = '0;
          wcnt_d  = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (illegal) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (bus_ok) begin
          rd_d    = ~cur_q.we;
          wd_d    = cur_q.we;
          wcnt_d  = 4'd1;             // strobe cycle counts as the first
          tcnt_d  = tcnt_inc[7:0];
          state_d = WAIT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d  = tcnt_inc[7:0];
        end
      end
      WAIT: begin
        // completion wins over timeout in the same cycle
        if (wcnt_q >= RLAT_C && bus_ok) begin
          cap     = 1'b1;
          state_d = RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d  = tcnt_inc[7:0];
          wcnt_d  = wcnt_inc;
        end
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q   <= '0;
      gnt_q   <= 1'b1;
      tcnt_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wd_q    <= 1'b0;
      rdstg_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
      if (grant) begin
        cur_q <= mreq[pick];
        gnt_q <= pick;
      end
      if (cap) rdstg_q <= bus_rdata;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_M; g++) begin : g_resp
      assign fire_v[g] = done & (gnt_q == 1'(g));
      dbus_arb_resp u_resp (
        .clk     (clk),
        .rst     (rst),
        .fire_i  (fire_v[g]),
        .err_i   (err_q),
        .upd_i   (~err_q & ~cur_q.we),
        .rdata_i (rdstg_q),
        .ack_o   (ack_v[g]),
        .err_o   (err_v[g]),
        .rdata_o (rdata_v[g])
      );
    end
  endgenerate

  assign m0_ack    = ack_v[0];
  assign m0_err    = err_v[0];
  assign m0_rdata  = rdata_v[0];
  assign m1_ack    = ack_v[1];
  assign m1_err    = err_v[1];
  assign m1_rdata  = rdata_v[1];

  assign bus_rd    = rd_q;
  assign bus_wd    = wd_q;
  assign bus_size  = cur_q.size;
  assign bus_addr  = cur_q.addr;
  assign bus_wdata = cur_q.wdata;
endmodule

// File: tb/tb_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbus_arbiter
//   Directed vector table, hand sequences (tie arbitration, reset mid-WAIT)
//   and randomized transactions checked against a transaction-level model.
//   Cycle 0 of a transaction is the cycle its req is first raised.
// -----------------------------------------------------------------------------
module tb_dbus_arbiter;
  localparam int RD_LAT = 1;
  localparam int TMO    = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_rd, bus_wd, bus_ready, bus_busy;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  dbus_arbiter #(.RD_LAT(RD_LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_rd(bus_rd), .bus_wd(bus_wd), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // per-cycle bus behaviour for the current transaction
  bit          rdy_a [64];
  bit          bsy_a [64];
  logic [31:0] rdt_a [64];
  logic [31:0] exp_rd [2];

  typedef struct {
    int          m;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] ad, wd, bd;
    int          stall;
    logic        eerr;
    int          elat, estr;
    logic [31:0] erd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int m, input logic v, input logic we,
                         input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    if (m == 0) begin m0_req = v; m0_we = we; m0_size = sz; m0_addr = ad; m0_wdata = wd; end
    else        begin m1_req = v; m1_we = we; m1_size = sz; m1_addr = ad; m1_wdata = wd; end
  endtask

  task automatic fill(input int stall, input logic [31:0] d);
    for (int c = 0; c < 64; c++) begin
      rdy_a[c] = (c > stall);
      bsy_a[c] = 1'b0;
      rdt_a[c] = d;
    end
  endtask

  function automatic logic legal(input logic [1:0] sz, input logic [31:0] ad);
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return ~ad[0];
      2'b10:   return ad[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Transaction-level reference: grant at end of cycle 0, ISSUE from cycle 1.
  // Cycle t (t>=1) is the t-th ISSUE/WAIT cycle; timeout when t reaches TMO.
  function automatic void model(input logic ill, output int ack, output logic err,
                                output int str, output logic [31:0] rd);
    int s;
    rd = 'x; str = -1; err = 1'b1; ack = -1; s = -1;
    if (ill) begin ack = 3; return; end
    for (int t = 1; t <= TMO; t++)
      if (rdy_a[t] && !bsy_a[t]) begin s = t; break; end
    if (s < 0) begin ack = TMO + 2; return; end
    str = s + 1;
    for (int u = s + 1; u < 62; u++) begin
      if (u - s >= RD_LAT && rdy_a[u] && !bsy_a[u]) begin
        ack = u + 2; err = 1'b0; rd = rdt_a[u]; return;
      end
      if (u >= TMO) begin ack = u + 2; return; end
    end
  endfunction

  task automatic do_txn(input int m, input logic we, input logic [1:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd, input bit drop,
                        output int ack_c, output logic err, output logic [31:0] rd,
                        output int str_c, output int nstr);
    logic a, oa;
    ack_c = -1; str_c = -1; nstr = 0; err = 1'bx; rd = 'x;
    set_req(m, 1'b1, we, sz, ad, wd);
    for (int c = 0; c < 64; c++) begin
      bus_ready = rdy_a[c]; bus_busy = bsy_a[c]; bus_rdata = rdt_a[c];
      if (drop && c == 1) begin if (m == 0) m0_req = 1'b0; else m1_req = 1'b0; end
      @(negedge clk);
      a  = (m == 0) ? m0_ack : m1_ack;
      oa = (m == 0) ? m1_ack : m0_ack;
      chk("strobe_excl", 32'(bus_rd & bus_wd), 0);
      chk("other_ack", 32'(oa), 0);
      if (bus_rd || bus_wd) begin
        nstr++;
        if (str_c < 0) str_c = c;
        chk("str_dir", 32'(bus_wd), 32'(we));
        chk("str_addr", bus_addr, ad);
        chk("str_size", 32'(bus_size), 32'(sz));
        chk("str_wdata", bus_wdata, wd);
      end
      if (a) begin
        ack_c = c;
        err = (m == 0) ? m0_err : m1_err;
        rd  = (m == 0) ? m0_rdata : m1_rdata;
        if (nstr > 0) begin
          chk("ack_addr_stable", bus_addr, ad);
          chk("ack_wdata_stable", bus_wdata, wd);
        end
        break;
      end
      @(posedge clk); #1;
    end
    if (ack_c < 0) chk("ack_timeout_bound", 32'(ack_c), 0);
    @(posedge clk); #1;
    set_req(m, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'b00, 0, 0);
    set_req(1, 1'b0, 1'b0, 2'b00, 0, 0);
    bus_ready = 1'b0; bus_busy = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {26'd0, m0_ack, m1_ack, m0_err, m1_err, bus_rd, bus_wd}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_bus_attr", bus_addr | bus_wdata | 32'(bus_size), 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Both masters request; each drops req after `per` acks. Records ack order.
  task automatic run_tie(input int per, output int who[4], output int cyc[4]);
    int served[2];
    int n;
    n = 0; served[0] = 0; served[1] = 0;
    for (int k = 0; k < 4; k++) begin who[k] = -1; cyc[k] = -1; end
    bus_ready = 1'b1; bus_busy = 1'b0; bus_rdata = 32'h600D0000;
    set_req(0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
    for (int c = 0; c < 60 && n < 2 * per; c++) begin
      @(negedge clk);
      chk("tie_ack_excl", 32'(m0_ack & m1_ack), 0);
      if (m0_ack && n < 4) begin who[n] = 0; cyc[n] = c; n++; served[0]++; end
      if (m1_ack && n < 4) begin who[n] = 1; cyc[n] = c; n++; served[1]++; end
      @(posedge clk); #1;
      if (served[0] >= per) m0_req = 1'b0;
      if (served[1] >= per) m1_req = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int who[4], cyc[4];
    int ack_c, str_c, nstr, eack, estr;
    logic err, eerr;
    logic [31:0] rd, erd;

    //            m we   sz     addr         wdata          bus_rdata     st eerr lat str rdata
    vt[0]  = '{0, 1'b0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1'b0, 4,  2, 32'hDEADBEEF};
    vt[1]  = '{1, 1'b1, 2'b01, 32'h21, 32'h1111,     32'h0,        0, 1'b1, 3, -1, 32'h0};
    vt[2]  = '{1, 1'b1, 2'b10, 32'h08, 32'hCAFEF00D, 32'h0,        0, 1'b0, 4,  2, 32'h0};
    vt[3]  = '{0, 1'b0, 2'b00, 32'h03, 32'h0,        32'h000000A5, 0, 1'b0, 4,  2, 32'h000000A5};
    vt[4]  = '{1, 1'b0, 2'b11, 32'h00, 32'h0,        32'h77777777, 0, 1'b1, 3, -1, 32'h0};
    vt[5]  = '{0, 1'b0, 2'b10, 32'h02, 32'h0,        32'h88888888, 0, 1'b1, 3, -1, 32'h000000A5};
    vt[6]  = '{0, 1'b0, 2'b01, 32'h02, 32'h0,        32'h0000BEEF, 2, 1'b0, 6,  4, 32'h0000BEEF};
    vt[7]  = '{1, 1'b0, 2'b10, 32'h40, 32'h0,        32'h12345678, 0, 1'b0, 4,  2, 32'h12345678};
    vt[8]  = '{1, 1'b0, 2'b10, 32'h44, 32'h0,        32'hFFFF0000, 20, 1'b1, 17, -1, 32'h12345678};
    vt[9]  = '{0, 1'b1, 2'b00, 32'h07, 32'h55,       32'h99999999, 0, 1'b0, 4,  2, 32'h0000BEEF};
    vt[10] = '{0, 1'b1, 2'b01, 32'h01, 32'h66,       32'h0,        0, 1'b1, 3, -1, 32'h0000BEEF};

    do_reset();

    // tie from reset: m0 first, then alternate while both keep requesting
    run_tie(2, who, cyc);
    chk("tie_who0", 32'(who[0]), 0); chk("tie_cyc0", 32'(cyc[0]), 4);
    chk("tie_who1", 32'(who[1]), 1); chk("tie_cyc1", 32'(cyc[1]), 8);
    chk("tie_who2", 32'(who[2]), 0); chk("tie_cyc2", 32'(cyc[2]), 12);
    chk("tie_who3", 32'(who[3]), 1); chk("tie_cyc3", 32'(cyc[3]), 16);
    // fresh tie after m1 was last granted: m0 wins
    run_tie(1, who, cyc);
    chk("tie2_who0", 32'(who[0]), 0); chk("tie2_cyc0", 32'(cyc[0]), 4);
    chk("tie2_who1", 32'(who[1]), 1); chk("tie2_cyc1", 32'(cyc[1]), 8);

    do_reset();

    foreach (vt[i]) begin
      fill(vt[i].stall, vt[i].bd);
      do_txn(vt[i].m, vt[i].we, vt[i].sz, vt[i].ad, vt[i].wd, 1'b0,
             ack_c, err, rd, str_c, nstr);
      chk($sformatf("vec%0d_lat", i), 32'(ack_c), 32'(vt[i].elat));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].eerr));
      chk($sformatf("vec%0d_str", i), 32'(str_c), 32'(vt[i].estr));
      chk($sformatf("vec%0d_nstr", i), 32'(nstr), (vt[i].estr < 0) ? 0 : 1);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].erd);
    end

    // req dropped right after grant: transaction still completes
    fill(0, 32'h13572468);
    do_txn(1, 1'b0, 2'b10, 32'h80, 32'h0, 1'b1, ack_c, err, rd, str_c, nstr);
    chk("drop_lat", 32'(ack_c), 4);
    chk("drop_rdata", rd, 32'h13572468);

    // reset while in WAIT: no ack, outputs back to reset, then normal service
    bus_busy = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h0;
    set_req(0, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    @(posedge clk); #1;                       // cycle 1: ISSUE, strobes
    @(posedge clk); #1;                       // cycle 2: WAIT
    bus_ready = 1'b0;
    @(negedge clk);
    chk("rw_strobe", 32'(bus_rd), 1);
    @(posedge clk); #1;                       // cycle 3: still WAIT
    rst = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    chk("rw_no_ack", 32'(m0_ack | m1_ack), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_flags", {26'd0, m0_ack, m1_ack, m0_err, m1_err, bus_rd, bus_wd}, 0);
    chk("rw_m0_rdata", m0_rdata, 0);
    chk("rw_bus_attr", bus_addr | bus_wdata | 32'(bus_size), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    fill(0, 32'h0BADCAFE);
    do_txn(0, 1'b0, 2'b10, 32'h24, 32'h0, 1'b0, ack_c, err, rd, str_c, nstr);
    chk("rw_after_lat", 32'(ack_c), 4);
    chk("rw_after_err", 32'(err), 0);
    chk("rw_after_rdata", rd, 32'h0BADCAFE);

    // randomized transactions against the model
    exp_rd[0] = 32'h0BADCAFE;
    exp_rd[1] = 32'h0;
    for (int i = 0; i < 60; i++) begin
      int m, r;
      logic we;
      logic [1:0] sz;
      logic [31:0] ad, wd;
      bit slow, drop;
      m  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 7);
      sz = (r < 7) ? 2'(r % 3) : 2'b11;
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ~32'h3;
      wd = $urandom;
      slow = ($urandom_range(0, 4) == 0);
      drop = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 64; c++) begin
        rdy_a[c] = slow ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
        bsy_a[c] = ($urandom_range(0, 4) == 0);
        rdt_a[c] = $urandom;
      end
      model(!legal(sz, ad), eack, eerr, estr, erd);
      do_txn(m, we, sz, ad, wd, drop, ack_c, err, rd, str_c, nstr);
      if (!eerr && !we) exp_rd[m] = erd;
      chk($sformatf("rnd%0d_lat", i), 32'(ack_c), 32'(eack));
      chk($sformatf("rnd%0d_err", i), 32'(err), 32'(eerr));
      chk($sformatf("rnd%0d_str", i), 32'(str_c), 32'(estr));
      chk($sformatf("rnd%0d_nstr", i), 32'(nstr), (estr < 0) ? 0 : 1);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd[m]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
